// File: rtl/csr_pkg.sv
// Shared definitions for the local CSR slaves: modify encodings, address map
// constants and the read-modify-write helper used by every writable register.
package csr_pkg;

   // Encodings of the modify bus; 4..7 behave like NONE
   localparam logic [2:0] CSR_MOD_NONE  = 3'd0;
   localparam logic [2:0] CSR_MOD_WRITE = 3'd1;
   localparam logic [2:0] CSR_MOD_SET   = 3'd2;
   localparam logic [2:0] CSR_MOD_CLEAR = 3'd3;

   // Identification registers (all read as zero)
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   // Writable machine counters
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   // Read-only user aliases
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_TIME      = 12'hC01;
   localparam logic [11:0] CSR_TIMEH     = 12'hC81;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

   // True when the modify code actually changes a register
   function automatic logic csr_is_modify(input logic [2:0] op);
      case (op)
         CSR_MOD_WRITE, CSR_MOD_SET, CSR_MOD_CLEAR: return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

   // New value of a 32-bit register after applying op with operand wdata
   function automatic logic [31:0] csr_apply(input logic [31:0] old,
                                             input logic [2:0]  op,
                                             input logic [31:0] wdata);
      case (op)
         CSR_MOD_WRITE: return wdata;
         CSR_MOD_SET:   return old | wdata;
         CSR_MOD_CLEAR: return old & ~wdata;
         default:       return old;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter whose halves can be modified independently.
// A write to either half suppresses that cycle's increment and never carries
// across the 32-bit boundary.
module csr_counter64
   import csr_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [2:0]  op,
   input  logic [31:0] wdata,
   output logic [63:0] value
);

   logic [63:0] value_q;
   logic [63:0] value_d;

   // Next counter value: half-modify takes priority over increment
   always_comb begin
      value_d = value_q;
      if (wr_lo || wr_hi) begin
         if (wr_lo) begin
            value_d[31:0] = csr_apply(value_q[31:0], op, wdata);
         end else begin
            value_d[31:0] = value_q[31:0];
         end
         if (wr_hi) begin
            value_d[63:32] = csr_apply(value_q[63:32], op, wdata);
         end else begin
            value_d[63:32] = value_q[63:32];
         end
      end else if (inc) begin
         value_d = value_q + 64'd1;
      end else begin
         value_d = value_q;
      end
   end

   // Counter state register with synchronous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= 64'd0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/csr_local_peripherals.sv
// Local CSR slaves on the side-bus: cycle/time/instret counters, ID registers,
// clock-rate register and a small output-pin register. Outputs are zero when
// this block does not own the latched address so they can be ORed with peers.
module csr_local_peripherals
   import csr_pkg::*;
#(
   parameter logic [11:0]           IDS_BASE   = 12'hFC0,
   parameter logic [31:0]           KHZ        = 32'd1000,
   parameter logic [11:0]           PINS_BASE  = 12'hBC1,
   parameter int unsigned           PINS_COUNT = 1,
   parameter logic [PINS_COUNT-1:0] PINS_RESET = {PINS_COUNT{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read,
   input  logic [2:0]            modify,
   input  logic [31:0]           wdata,
   input  logic [11:0]           addr,
   output logic [31:0]           rdata,
   output logic                  valid,
   input  logic                  retired,
   output logic [PINS_COUNT-1:0] pins
);

   logic [11:0]           addr_q;
   logic                  read_q;
   logic [PINS_COUNT-1:0] pins_q;
   logic [PINS_COUNT-1:0] pins_d;

   logic                  mod_s;
   logic [63:0]           cycle_s;
   logic [63:0]           instret_s;
   logic [31:0]           pins_ext_s;
   logic [31:0]           pins_new_s;
   logic                  hit_s;
   logic [31:0]           sel_s;

   // The modify bus targets the address latched in the previous cycle
   assign mod_s = csr_is_modify(modify);

   csr_counter64 u_cycle (
      .clk   (clk),
      .rst   (rst),
      .inc   (1'b1),
      .wr_lo (mod_s && (addr_q == CSR_MCYCLE)),
      .wr_hi (mod_s && (addr_q == CSR_MCYCLEH)),
      .op    (modify),
      .wdata (wdata),
      .value (cycle_s)
   );

   csr_counter64 u_instret (
      .clk   (clk),
      .rst   (rst),
      .inc   (retired),
      .wr_lo (mod_s && (addr_q == CSR_MINSTRET)),
      .wr_hi (mod_s && (addr_q == CSR_MINSTRETH)),
      .op    (modify),
      .wdata (wdata),
      .value (instret_s)
   );

   // Zero-extend the pin register to a full CSR word
   always_comb begin
      pins_ext_s = 32'd0;
      pins_ext_s[PINS_COUNT-1:0] = pins_q;
   end

   assign pins_new_s = csr_apply(pins_ext_s, modify, wdata);

   // Pin next state: only the implemented low bits are kept
   always_comb begin
      pins_d = pins_q;
      if (mod_s && (addr_q == PINS_BASE)) begin
         pins_d = pins_new_s[PINS_COUNT-1:0];
      end else begin
         pins_d = pins_q;
      end
   end

   // Address/read latch and pin register; reset drops any pending access
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= 12'd0;
         read_q <= 1'b0;
         pins_q <= PINS_RESET;
      end else begin
         addr_q <= addr;
         read_q <= read;
         pins_q <= pins_d;
      end
   end

   // Address decode and read-data select for the latched address
   always_comb begin
      hit_s = 1'b0;
      sel_s = 32'd0;
      if (addr_q == IDS_BASE) begin
         hit_s = 1'b1;
         sel_s = KHZ;
      end else if (addr_q == PINS_BASE) begin
         hit_s = 1'b1;
         sel_s = pins_ext_s;
      end else begin
         case (addr_q)
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: begin
               hit_s = 1'b1;
               sel_s = 32'd0;
            end
            CSR_MCYCLE, CSR_CYCLE, CSR_TIME: begin
               hit_s = 1'b1;
               sel_s = cycle_s[31:0];
            end
            CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH: begin
               hit_s = 1'b1;
               sel_s = cycle_s[63:32];
            end
            CSR_MINSTRET, CSR_INSTRET: begin
               hit_s = 1'b1;
               sel_s = instret_s[31:0];
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
               hit_s = 1'b1;
               sel_s = instret_s[63:32];
            end
            default: begin
               hit_s = 1'b0;
               sel_s = 32'd0;
            end
         endcase
      end
   end

   // Bus outputs: drive zero unless this block owns a requested read
   always_comb begin
      valid = read_q & hit_s;
      if (valid) begin
         rdata = sel_s;
      end else begin
         rdata = 32'd0;
      end
   end

   assign pins = pins_q;

endmodule

// File: tb/tb_csr_local_peripherals.sv
module tb_csr_local_peripherals;

   localparam logic [11:0] IDS  = 12'hFC0;
   localparam logic [11:0] PINA = 12'hBC1;
   localparam logic [2:0]  WR   = 3'd1;
   localparam logic [2:0]  ST   = 3'd2;
   localparam logic [2:0]  CL   = 3'd3;

   logic        clk = 1'b0;
   logic        rst, read, valid, retired;
   logic [2:0]  modify;
   logic [31:0] wdata, rdata;
   logic [11:0] addr;
   logic [0:0]  pins;

   always #5 clk = ~clk;

   csr_local_peripherals #(
      .IDS_BASE(12'hFC0), .KHZ(32'd1000), .PINS_BASE(12'hBC1),
      .PINS_COUNT(1), .PINS_RESET(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .read(read), .modify(modify), .wdata(wdata),
      .addr(addr), .rdata(rdata), .valid(valid), .retired(retired), .pins(pins)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model state
   logic [63:0] m_cyc, m_ins;
   logic        m_pins;
   logic [11:0] m_paddr;
   logic        m_pread;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mod32(input logic [31:0] old, input logic [2:0] op,
                                         input logic [31:0] wd);
      if (op == 3'd1)      return wd;
      else if (op == 3'd2) return old | wd;
      else if (op == 3'd3) return old & ~wd;
      else                 return old;
   endfunction

   // {owned, value} for an address under the current model state
   function automatic logic [32:0] model_read(input logic [11:0] a);
      case (a)
         12'hFC0:                            return {1'b1, 32'd1000};
         12'hF11, 12'hF12, 12'hF13, 12'hF14: return {1'b1, 32'd0};
         12'hB00, 12'hC00, 12'hC01:          return {1'b1, m_cyc[31:0]};
         12'hB80, 12'hC80, 12'hC81:          return {1'b1, m_cyc[63:32]};
         12'hB02, 12'hC02:                   return {1'b1, m_ins[31:0]};
         12'hB82, 12'hC82:                   return {1'b1, m_ins[63:32]};
         12'hBC1:                            return {1'b1, 31'd0, m_pins};
         default:                            return {1'b0, 32'd0};
      endcase
   endfunction

   // Model of one clock edge using the inputs currently driven
   task automatic model_edge();
      logic        dm;
      logic [31:0] t;
      if (rst) begin
         m_cyc = 64'd0; m_ins = 64'd0; m_pins = 1'b0;
         m_paddr = 12'd0; m_pread = 1'b0;
      end else begin
         dm = (modify >= 3'd1) && (modify <= 3'd3);
         if (dm && m_paddr == 12'hB00)      m_cyc = {m_cyc[63:32], mod32(m_cyc[31:0], modify, wdata)};
         else if (dm && m_paddr == 12'hB80) m_cyc = {mod32(m_cyc[63:32], modify, wdata), m_cyc[31:0]};
         else                               m_cyc = m_cyc + 64'd1;
         if (dm && m_paddr == 12'hB02)      m_ins = {m_ins[63:32], mod32(m_ins[31:0], modify, wdata)};
         else if (dm && m_paddr == 12'hB82) m_ins = {mod32(m_ins[63:32], modify, wdata), m_ins[31:0]};
         else if (retired)                  m_ins = m_ins + 64'd1;
         if (dm && m_paddr == 12'hBC1) begin
            t = mod32({31'd0, m_pins}, modify, wdata);
            m_pins = t[0];
         end
         m_paddr = addr;
         m_pread = read;
      end
   endtask

   // Drive one cycle, advance the model, then compare all outputs
   task automatic step(input logic r, input logic rd, input logic [11:0] a,
                       input logic [2:0] op, input logic [31:0] wd, input logic ret,
                       input string tag);
      logic [32:0] mr;
      logic        ev;
      rst = r; read = rd; addr = a; modify = op; wdata = wd; retired = ret;
      @(posedge clk);
      model_edge();
      #1;
      mr = model_read(m_paddr);
      ev = m_pread & mr[32];
      check({tag, " valid"}, {31'd0, valid}, {31'd0, ev});
      check({tag, " rdata"}, rdata, ev ? mr[31:0] : 32'd0);
      check({tag, " pins"},  {31'd0, pins}, {31'd0, m_pins});
   endtask

   typedef struct {
      logic        rd;
      logic [11:0] a;
      logic [2:0]  op;
      logic [31:0] wd;
      logic        ev;
      logic [31:0] er;
      logic        ep;
   } vec_t;

   vec_t tbl [14];

   logic [11:0] alist [23];

   initial begin : main
      logic [31:0] v0, v1, v2;
      logic [11:0] ra;
      logic [31:0] rw;

      // op in each row applies to the address of the previous row
      tbl[0]  = '{1'b1, 12'hFC0, 3'd0, 32'd0,          1'b1, 32'd1000, 1'b0};
      tbl[1]  = '{1'b1, 12'hF14, 3'd0, 32'd0,          1'b1, 32'd0,    1'b0};
      tbl[2]  = '{1'b1, 12'h123, 3'd0, 32'd0,          1'b0, 32'd0,    1'b0};
      tbl[3]  = '{1'b1, 12'hF11, 3'd0, 32'd0,          1'b1, 32'd0,    1'b0};
      tbl[4]  = '{1'b1, 12'hBC1, 3'd0, 32'd0,          1'b1, 32'd0,    1'b0};
      tbl[5]  = '{1'b1, 12'hBC1, WR,   32'hFFFF_FFFF,  1'b1, 32'd1,    1'b1};
      tbl[6]  = '{1'b1, 12'hBC1, CL,   32'd1,          1'b1, 32'd0,    1'b0};
      tbl[7]  = '{1'b1, 12'hBC1, ST,   32'd1,          1'b1, 32'd1,    1'b1};
      tbl[8]  = '{1'b0, 12'hC00, 3'd0, 32'd0,          1'b0, 32'd0,    1'b1};
      tbl[9]  = '{1'b1, 12'hFC0, WR,   32'h55,         1'b1, 32'd1000, 1'b1};
      tbl[10] = '{1'b1, 12'hFC0, WR,   32'h55,         1'b1, 32'd1000, 1'b1};
      tbl[11] = '{1'b1, 12'hF12, WR,   32'h55,         1'b1, 32'd0,    1'b1};
      tbl[12] = '{1'b1, 12'hF13, 3'd5, 32'd0,          1'b1, 32'd0,    1'b1};
      tbl[13] = '{1'b1, 12'h123, WR,   32'h0,          1'b0, 32'd0,    1'b1};

      alist = '{12'hFC0, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hB00, 12'hB80,
                12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02,
                12'hC82, 12'hBC1, 12'hBC1, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                12'h000, 12'h7FF};

      // Reset for three cycles, then watch the cycle counter run
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "reset");
      check("reset valid", {31'd0, valid}, 32'd0);
      step(1'b0, 1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "cyc0"); v0 = rdata;
      step(1'b0, 1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "cyc1"); v1 = rdata;
      step(1'b0, 1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "cyc2"); v2 = rdata;
      check("cyc start le 3", {31'd0, (v0 <= 32'd3)}, 32'd1);
      check("cyc step 1", v1, v0 + 32'd1);
      check("cyc step 2", v2, v1 + 32'd1);
      step(1'b0, 1'b1, 12'hC80, 3'd0, 32'd0, 1'b0, "cych");
      check("cych zero", rdata, 32'd0);

      // Table of deterministic accesses
      for (int i = 0; i < 14; i++) begin
         step(1'b0, tbl[i].rd, tbl[i].a, tbl[i].op, tbl[i].wd, 1'b0, $sformatf("tbl%0d", i));
         check($sformatf("tbl%0d valid const", i), {31'd0, valid}, {31'd0, tbl[i].ev});
         check($sformatf("tbl%0d rdata const", i), rdata, tbl[i].er);
         check($sformatf("tbl%0d pins const", i), {31'd0, pins}, {31'd0, tbl[i].ep});
      end

      // Low half written near wrap, then carries into the high half
      step(1'b0, 1'b0, 12'hB00, 3'd0, 32'd0, 1'b0, "wrap a");
      step(1'b0, 1'b1, 12'hC00, WR, 32'hFFFF_FFFE, 1'b0, "wrap b");
      check("wrap written", rdata, 32'hFFFF_FFFE);
      step(1'b0, 1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "wrap c");
      check("wrap max", rdata, 32'hFFFF_FFFF);
      step(1'b0, 1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "wrap d");
      check("wrap zero", rdata, 32'd0);
      step(1'b0, 1'b1, 12'hC80, 3'd0, 32'd0, 1'b0, "wrap e");
      check("wrap carry", rdata, 32'd1);

      // Instret counts five retirements; a write wins over retire
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 12'h000, 3'd0, 32'd0, 1'b1, "ret");
      step(1'b0, 1'b1, 12'hB02, 3'd0, 32'd0, 1'b0, "ret rd");
      check("instret five", rdata, 32'd5);
      step(1'b0, 1'b0, 12'hB02, 3'd0, 32'd0, 1'b0, "ret a");
      step(1'b0, 1'b1, 12'hB02, WR, 32'd7, 1'b1, "ret wr");
      check("instret write wins", rdata, 32'd7);

      // Reset restores pins and discards a pending counter write
      step(1'b0, 1'b0, 12'hB00, 3'd0, 32'd0, 1'b0, "rst a");
      step(1'b1, 1'b1, 12'hC00, WR, 32'h1234, 1'b0, "rst b");
      check("rst pins", {31'd0, pins}, 32'd0);
      check("rst valid", {31'd0, valid}, 32'd0);
      step(1'b0, 1'b1, 12'hC00, 3'd0, 32'd0, 1'b0, "rst c");
      check("rst discard", rdata, 32'd1);

      // Randomised traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) ra = 12'($urandom);
         else                           ra = alist[$urandom_range(0, 22)];
         case ($urandom_range(0, 3))
            0:       rw = 32'hFFFF_FFFF;
            1:       rw = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: rw = $urandom;
         endcase
         step(($urandom_range(0, 63) == 0), 1'($urandom), ra, 3'($urandom_range(0, 7)),
              rw, 1'($urandom), $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
